// File: rtl/mul163_digit_ctrl_if.sv
// rtl/mul163_digit_ctrl_if.sv - operand/feed/result bundle for the GF(2^163) digit-serial controller
interface mul163_digit_ctrl_if #(
  parameter int M      = 163,
  parameter int DIGITS = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [M-1:0]      a_in;
  logic [M-1:0]      b_in;
  logic [M-1:0]      a_out;
  logic [DIGITS-1:0] b_digit_out;
  logic              first_out;
  logic              feed_valid;
  logic [M-1:0]      t_in;
  logic [M-1:0]      c_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport slave (
    input  in_valid, a_in, b_in, t_in, out_ready,
    output in_ready, a_out, b_digit_out, first_out, feed_valid, c_out, out_valid, busy
  );

  modport master (
    output in_valid, a_in, b_in, t_in, out_ready,
    input  in_ready, a_out, b_digit_out, first_out, feed_valid, c_out, out_valid, busy
  );
endinterface

// File: rtl/mul163_digit_ctrl.sv
// rtl/mul163_digit_ctrl.sv - feeds B MSB-digit-first to the PE rows and captures the product
module mul163_digit_ctrl #(
  parameter int M        = 163,
  parameter int DIGITS   = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  mul163_digit_ctrl_if.slave    bus
);
  localparam int NDIG = (M + DIGITS - 1) / DIGITS;
  localparam int BW   = NDIG * DIGITS;
  localparam int KW   = $clog2(NDIG);
  localparam int DW   = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [M-1:0]      r_a;
  logic [BW-1:0]     r_shift;
  logic [KW-1:0]     r_k;
  logic [DW-1:0]     r_drain;
  logic [DIGITS-1:0] r_digit;
  logic              r_first;
  logic              r_feed;
  logic [M-1:0]      r_c;
  logic              r_out_valid;
  logic [BW-1:0]     w_bp;

  assign w_bp = {{(BW - M){1'b0}}, bus.b_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_shift     <= '0;
      r_k         <= '0;
      r_drain     <= '0;
      r_digit     <= '0;
      r_first     <= 1'b0;
      r_feed      <= 1'b0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // The top digit goes out straight from the accept edge; the rest shift up behind it.
            r_a     <= bus.a_in;
            r_digit <= w_bp[BW-1 -: DIGITS];
            r_shift <= w_bp << DIGITS;
            r_k     <= KW'(NDIG - 1);
            r_first <= 1'b1;
            r_feed  <= 1'b1;
            r_state <= S_FEED;
          end
        end
        S_FEED: begin
          r_first <= 1'b0;
          if (r_k == '0) begin
            r_feed  <= 1'b0;
            r_digit <= '0;
            r_drain <= DW'(PIPE_LAT);
            r_state <= S_DRAIN;
          end else begin
            r_digit <= r_shift[BW-1 -: DIGITS];
            r_shift <= r_shift << DIGITS;
            r_k     <= r_k - KW'(1);
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain - DW'(1);
          if (r_drain == DW'(1)) begin
            r_c         <= bus.t_in;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.a_out       = r_a;
  assign bus.b_digit_out = r_digit;
  assign bus.first_out   = r_first;
  assign bus.feed_valid  = r_feed;
  assign bus.c_out       = r_c;
  assign bus.out_valid   = r_out_valid;
endmodule

// File: tb/tb_mul163_digit_ctrl.sv
// tb/tb_mul163_digit_ctrl.sv - self-checking bench for mul163_digit_ctrl
module tb_mul163_digit_ctrl;
  localparam int M  = 163;
  localparam int PL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul163_digit_ctrl_if #(.M(M), .DIGITS(8)) bus();
  mul163_digit_ctrl #(.M(M), .DIGITS(8), .PIPE_LAT(PL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [7:0]   d0;
    logic [M-1:0] c;
  } vec_t;
  vec_t vt[6];

  function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
    logic [M-1:0] red;
    red = v[M-1] ? M'(8'hC9) : {M{1'b0}};
    return {v[M-2:0], 1'b0} ^ red;
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = mulx(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] dmul(input logic [M-1:0] a, input logic [7:0] d);
    logic [M-1:0] r = '0;
    for (int j = 7; j >= 0; j--) begin
      r = mulx(r);
      if (d[j]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[M-1:0];
  endfunction

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural PE array: Horner accumulation of A*digit, result visible PL cycle after the last digit.
  logic [M-1:0] m_acc  = '0;
  logic         m_pend = 1'b0;
  logic [M-1:0] m_junk = '0;
  always @(posedge clk) begin
    if (bus.feed_valid === 1'b1) begin
      m_acc  <= (bus.first_out === 1'b1) ? dmul(bus.a_out, bus.b_digit_out)
                : (mulx(mulx(mulx(mulx(mulx(mulx(mulx(mulx(m_acc)))))))) ^ dmul(bus.a_out, bus.b_digit_out));
      m_pend <= 1'b1;
    end else begin
      m_pend <= 1'b0;
    end
    m_junk <= rand163();
  end
  assign bus.t_in = (m_pend && bus.feed_valid !== 1'b1) ? m_acc : m_junk;

  logic [M-1:0] sb[$];
  int           cyc        = 0;
  int           acc_cyc    = 0;
  int           b2b_last   = -1;
  bit           b2b        = 1'b0;
  bit           job_active = 1'b0;
  logic [167:0] job_b      = '0;
  int           firsts     = 0;
  int           pops       = 0;

  initial begin
    int rel;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst === 1'b1) begin
        sb.delete();
        job_active = 1'b0;
      end else begin
        if (job_active) begin
          rel = cyc - acc_cyc;
          if (rel >= 1 && rel <= 21) begin
            chk("feed_valid", M'(bus.feed_valid), M'(1));
            chk("digit", M'(bus.b_digit_out), M'(job_b[8*(21-rel) +: 8]));
            chk("first_out", M'(bus.first_out), M'(rel == 1));
            if (bus.first_out === 1'b1) firsts++;
          end else if (rel == 21 + PL) begin
            chk("drain_feed", M'(bus.feed_valid), M'(0));
            chk("drain_ovalid", M'(bus.out_valid), M'(0));
          end else if (rel == 22 + PL) begin
            chk("ovalid_rise", M'(bus.out_valid), M'(1));
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", M'(1), M'(0));
          end else begin
            chk("sb_product", bus.c_out, sb.pop_front());
            chk("first_once", M'(firsts), M'(1));
            pops++;
          end
          job_active = 1'b0;
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
          if (b2b) begin
            if (b2b_last >= 0) chk("accept_spacing", M'(cyc - b2b_last), M'(23 + PL));
            b2b_last = cyc;
          end
          sb.push_back(gf_mul(bus.a_in, bus.b_in));
          acc_cyc    = cyc;
          job_b      = {5'b0, bus.b_in};
          job_active = 1'b1;
          firsts     = 0;
        end
      end
    end
  end

  task automatic start_job(input logic [M-1:0] a, input logic [M-1:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("start_ready", M'(bus.in_ready), M'(1));
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int           n;
    int           bad;
    int           seen;
    int           pops0;
    logic [M-1:0] held;
    logic [M-1:0] ea;
    logic [M-1:0] eb;
    logic [M-1:0] ones;
    logic [M-1:0] top;

    ones = {M{1'b1}};
    top  = {1'b1, {(M-1){1'b0}}};

    // Reset with live inputs: rst must win over in_valid.
    bus.in_valid  = 1'b1;
    bus.a_in      = rand163();
    bus.b_in      = rand163();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_in_ready", M'(bus.in_ready), M'(1));
    chk("rst_busy", M'(bus.busy), M'(0));
    chk("rst_out_valid", M'(bus.out_valid), M'(0));
    chk("rst_feed_valid", M'(bus.feed_valid), M'(0));
    chk("rst_first", M'(bus.first_out), M'(0));
    chk("rst_digit", M'(bus.b_digit_out), M'(0));
    chk("rst_a_out", bus.a_out, M'(0));
    chk("rst_c_out", bus.c_out, M'(0));
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();

    ea = rand163();
    eb = rand163();
    vt[0] = '{M'(1), M'(1), 8'h00, M'(1)};
    vt[1] = '{top, M'(2), 8'h00, M'(8'hC9)};
    vt[2] = '{ea, ones, 8'h07, gf_mul(ea, ones)};
    vt[3] = '{ones, ones, 8'h07, gf_mul(ones, ones)};
    vt[4] = '{M'(0), eb, {5'b0, eb[M-1 -: 3]}, M'(0)};
    vt[5] = '{ea, eb, {5'b0, eb[M-1 -: 3]}, gf_mul(ea, eb)};

    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_job(vt[i].a, vt[i].b);
      chk("first_digit", M'(bus.b_digit_out), M'(vt[i].d0));
      chk("first_flag", M'(bus.first_out), M'(1));
      wait_out(n);
      chk("latency", M'(n), M'(22 + PL));
      chk("product", bus.c_out, vt[i].c);
      chk("a_out_held", bus.a_out, vt[i].a);
      tick();
      chk("release_ovalid", M'(bus.out_valid), M'(0));
      chk("release_ready", M'(bus.in_ready), M'(1));
    end

    // Backpressure with an in_valid pulse during the stall.
    bus.out_ready = 1'b0;
    ea = rand163();
    eb = rand163();
    start_job(ea, eb);
    wait_out(n);
    chk("bp_latency", M'(n), M'(22 + PL));
    held = bus.c_out;
    bad  = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid !== 1'b1 || bus.c_out !== held || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      if (i == 20) begin
        bus.a_in     = rand163();
        bus.b_in     = rand163();
        bus.in_valid = 1'b1;
      end
      if (i == 21) bus.in_valid = 1'b0;
      tick();
    end
    chk("stall_stable", M'(bad), M'(0));
    chk("stall_product", held, gf_mul(ea, eb));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_ovalid", M'(bus.out_valid), M'(0));
    chk("bp_release_ready", M'(bus.in_ready), M'(1));

    // Reset in the tenth FEED cycle.
    start_job(rand163(), rand163());
    repeat (9) tick();
    chk("mid_feed_active", M'(bus.feed_valid), M'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_feed", M'(bus.feed_valid), M'(0));
    chk("mid_rst_ready", M'(bus.in_ready), M'(1));
    chk("mid_rst_busy", M'(bus.busy), M'(0));
    seen = 0;
    repeat (40) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    chk("no_out_after_rst", M'(seen), M'(0));
    ea = rand163();
    eb = rand163();
    start_job(ea, eb);
    wait_out(n);
    chk("post_rst_latency", M'(n), M'(22 + PL));
    chk("post_rst_product", bus.c_out, gf_mul(ea, eb));
    tick();

    // Back-to-back jobs with out_ready tied high.
    pops0 = pops;
    b2b   = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.a_in     = rand163();
      bus.b_in     = rand163();
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("sb_drained", M'(sb.size()), M'(0));
    chk("b2b_jobs", M'(pops - pops0), M'(20));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mul163_digit_ctrl.md
Name: mul163_digit_ctrl

Overview:
- Sequential front/back-end controller for the GF(2^163) digit-serial systolic multiplier with 8-bit digits.
- Accepts an operand pair A, B over a valid/ready handshake and holds A stable for the PE array.
- Streams B to the PE rows one 8-bit digit per cycle, MSB digit first, then waits out the array latency, captures the 163-bit product and presents it over a valid/ready handshake.
- Sits directly upstream of the PE rows (drives their b and a inputs) and downstream of their final t outputs.

Parameters:
M, 163, field degree / operand width
DIGITS, 8, digit width (bits of B consumed per cycle)
NDIG, 21, number of digits = ceil(M/DIGITS); derived, not overridden
PIPE_LAT, 1, cycles from last digit on b_digit_out to valid t_in; legal range 1..7

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
a_in  input  M  operand A
b_in  input  M  operand B
a_out  output  M  latched A to PE array
b_digit_out  output  DIGITS  current B digit to PE array
first_out  output  1  marks first digit; array clears its accumulator
feed_valid  output  1  b_digit_out is a live digit
t_in  input  M  product from last PE stage
c_out  output  M  captured product
out_valid  output  1  c_out valid
out_ready  input  1  consumer accepts c_out
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state IDLE, a_out=0, b_digit_out=0, first_out=0, feed_valid=0, c_out=0, out_valid=0, busy=0, in_ready=1.
- in_ready is high only in IDLE.
- B padding: internal Bp = {5'b0, b_in}, giving 168 bits. Digit k = Bp[8k+7:8k], k=0..20.
- States:
  - IDLE:
    - On in_valid & in_ready, latch a_in into a_out and Bp into the shift register, set the digit counter to 20, and go to FEED.
    - Otherwise stay in IDLE.
  - FEED:
    - feed_valid=1; b_digit_out = digit counter k, issued in order k = 20, 19, …, 0.
    - first_out=1 only in the k=20 cycle.
    - After the k=0 cycle, go to DRAIN and load the drain counter with PIPE_LAT.
  - DRAIN:
    - feed_valid=0, b_digit_out=0, first_out=0.
    - Decrement the counter each cycle.
    - At the clock edge ending the last drain cycle, register t_in into c_out and go to DONE.
  - DONE:
    - out_valid=1; c_out held stable.
    - On out_valid & out_ready, go to IDLE next cycle with out_valid=0.
    - c_out retains its value until the next capture.
- Timing: operands accepted at the edge ending cycle 0.
  - FEED occupies cycles 1..21.
  - DRAIN occupies cycles 22..21+PIPE_LAT.
  - out_valid first high in cycle 22+PIPE_LAT (cycle 23 at the default).
- a_out is constant from cycle 1 until the next accept.
- Outputs are registered; nothing depends combinationally on in_valid or out_ready except the accept/release decisions.
- Boundary conditions:
  - in_valid while busy: ignored, operands not sampled; the source must hold them until in_ready.
  - out_ready high in the same cycle out_valid first rises: accepted in that cycle; IDLE the next cycle.
  - out_ready low indefinitely: remain in DONE; in_ready stays 0 (no overlap of jobs).
  - Back-to-back jobs: minimum spacing between accepts is 23+PIPE_LAT cycles (one IDLE cycle after release).
  - rst mid-operation (any state): next cycle equals the reset values. An in-flight job is discarded and no out_valid is produced for it.
  - rst and in_valid in the same cycle: rst wins; nothing is latched.
  - t_in is sampled only at the capture edge; at all other times it is don't-care.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all outputs at reset values, in_ready=1, busy=0.
- A=1, B=1, PIPE_LAT=1, with a behavioural array model -> feed_valid high in cycles 1..21.
  - Digits 20..1 are 0x00; digit 0 is 0x01; first_out only in cycle 1.
  - out_valid in cycle 23 with c_out=1.
- B=all ones (2^163-1) -> first digit 0x07, remaining 20 digits 0xFF.
  - Product matches a reference GF(2^163) multiply modulo x^163+x^7+x^6+x^3+1.
- Backpressure: out_ready low for 50 cycles after out_valid -> out_valid and c_out stable throughout; in_ready=0.
  - A new in_valid pulse during the stall is not accepted.
  - Raising out_ready releases the result; in_ready=1 on the next cycle.
- Mid-job reset: rst asserted in cycle 10 of FEED -> feed_valid=0 and in_ready=1 the next cycle.
  - No out_valid follows; a new job started afterwards completes correctly.
- Back-to-back: 20 random operand pairs with out_ready tied high -> every product matches the model, accepts are exactly 24 cycles apart, and first_out occurs exactly once per job.
